// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
//
// Synchronous-read instruction memory for the mini-CPU fetch stage, with a
// byte-serial program loader so a new program image can be written at run
// time (e.g. streamed in from the UART) instead of being re-synthesised.
//
// A fetch request is answered exactly one cycle later with a valid strobe.
// While a program is being loaded the fetch port is dead: the CPU must stall
// on loading_o, and instr_o parks at DEFAULT_INSTR.
//
// Loader bytes are little-endian within a word. Once a full word has been
// assembled it is committed to the next free location; words that do not
// fit, or a partial word left over at load_done_i, are dropped and flagged
// on the sticky load_error_o.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous, active-high reset (memory contents survive)
//   addr_i         fetch address (instruction pointer)
//   fetch_en_i     request a fetch of addr_i this cycle
//   instr_o        registered instruction word
//   instr_valid_o  1-cycle strobe: instr_o is the result of a fetch
//   load_start_i   enter / restart program load, write pointer back to 0
//   load_valid_i   load_byte_i is valid this cycle
//   load_byte_i    program byte
//   load_ready_o   loader accepts a byte (valid & ready) while high
//   load_done_i    end of program image, return to normal fetch
//   loading_o      high while loading; the CPU must stall
//   load_count_o   words committed by the current or last load
//   load_error_o   sticky: overflow or partial word at load_done_i
//
// States
//   ST_RUN  | normal operation, fetch port active, loader not ready
//   ST_LOAD | program load, bytes accepted, fetches ignored
// -----------------------------------------------------------------------------
module instr_mem_loadable #(
    parameter int                    DATA_WIDTH    = 28,
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    DEPTH         = 256,
    // LED opcode with the 0xAA pattern: a harmless instruction that makes a
    // stray fetch from unmapped space visible on the board.
    parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = {4'h6, 24'hAA},
    parameter                        INIT_FILE     = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  fetch_en_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  instr_valid_o,

    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_byte_i,
    output logic                  load_ready_o,
    input  logic                  load_done_i,
    output logic                  loading_o,
    output logic [ADDR_WIDTH-1:0] load_count_o,
    output logic                  load_error_o
);

    localparam int BYTES  = (DATA_WIDTH + 7) / 8;
    localparam int ASM_W  = BYTES * 8;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the pointer can sit at DEPTH after the memory fills.
    localparam int PTR_W  = ADDR_WIDTH + 1;

    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    valid_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic                    err_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [ASM_W-1:0]        asm_q;
    logic [ASM_W-1:0]        asm_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    fetch_hit;
    logic [MEM_AW-1:0]       rd_idx;
    logic [MEM_AW-1:0]       wr_idx;
    logic                    byte_take;
    logic                    word_full;
    logic                    ptr_ok;
    logic                    mem_we;

    always_comb begin
        fetch_hit = ({1'b0, addr_i} < DEPTH_P);
        rd_idx    = addr_i[MEM_AW-1:0];
        wr_idx    = ptr_q[MEM_AW-1:0];
        ptr_ok    = (ptr_q < DEPTH_P);

        // A restart discards whatever byte arrives alongside it.
        byte_take = (state_q == ST_LOAD) && !load_start_i && load_valid_i;
        word_full = byte_take && (idx_q == LAST_IDX);
        mem_we    = word_full && ptr_ok;

        asm_d = asm_q;
        idx_d = idx_q;
        if (byte_take) begin
            asm_d[{idx_q, 3'b000} +: 8] = load_byte_i;
            idx_d = word_full ? '0 : idx_q + 1'b1;
        end
    end

    // Write uses asm_d so the final byte of a word lands in the same edge.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_idx] <= asm_d[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            instr_q <= DEFAULT_INSTR;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            asm_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_start_i) begin
                        state_q <= ST_LOAD;
                        instr_q <= DEFAULT_INSTR;
                        valid_q <= 1'b0;
                        ptr_q   <= '0;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        asm_q   <= '0;
                    end else if (fetch_en_i) begin
                        valid_q <= 1'b1;
                        instr_q <= fetch_hit ? mem[rd_idx] : DEFAULT_INSTR;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    instr_q <= DEFAULT_INSTR;
                    valid_q <= 1'b0;
                    if (load_start_i) begin
                        ptr_q   <= '0;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        asm_q   <= '0;
                    end else begin
                        asm_q <= asm_d;
                        idx_q <= idx_d;
                        if (word_full) begin
                            if (ptr_ok) begin
                                ptr_q   <= ptr_q + 1'b1;
                                count_q <= count_q + 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        // idx_d already includes this cycle's byte, so a byte
                        // that completes a word together with done is clean.
                        if (load_done_i) begin
                            state_q <= ST_RUN;
                            idx_q   <= '0;
                            asm_q   <= '0;
                            if (idx_d != '0) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign loading_o     = (state_q == ST_LOAD);
    assign load_ready_o  = (state_q == ST_LOAD);
    assign load_count_o  = count_q;
    assign load_error_o  = err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

    localparam int DW    = 28;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam logic [DW-1:0] DEF = 28'h60000AA;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic          fe;
    logic [DW-1:0] instr;
    logic          ivalid;
    logic          ls;
    logic          lv;
    logic [7:0]    lb;
    logic          lready;
    logic          ld;
    logic          loading;
    logic [AW-1:0] lcount;
    logic          lerr;

    int nvec;
    int nbad;

    instr_mem_loadable #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .DEFAULT_INSTR(DEF),
        .INIT_FILE    ("")
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (addr),
        .fetch_en_i   (fe),
        .instr_o      (instr),
        .instr_valid_o(ivalid),
        .load_start_i (ls),
        .load_valid_i (lv),
        .load_byte_i  (lb),
        .load_ready_o (lready),
        .load_done_i  (ld),
        .loading_o    (loading),
        .load_count_o (lcount),
        .load_error_o (lerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          fe;
        logic [AW-1:0] addr;
        logic          ls;
        logic          lv;
        logic [7:0]    lb;
        logic          ld;
        logic          ev;
        logic [DW-1:0] ei;
        logic          eld;
        logic [AW-1:0] ec;
        logic          ee;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic f, int a, logic s, logic v, logic [7:0] b,
                                logic d, logic ev, logic [DW-1:0] ei, logic eld,
                                int ec, logic ee);
        vec_t t;
        t.rst = r;  t.fe = f;  t.addr = AW'(a); t.ls = s; t.lv = v; t.lb = b; t.ld = d;
        t.ev = ev;  t.ei = ei; t.eld = eld;     t.ec = AW'(ec); t.ee = ee;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; fe = 1'b0; addr = '0; ls = 1'b0; lv = 1'b0; lb = '0; ld = 1'b0;
    endtask

    task automatic check(string name, logic ev, logic [DW-1:0] ei, logic eld,
                         logic [AW-1:0] ec, logic ee);
        nvec++;
        if (ivalid !== ev || instr !== ei || loading !== eld || lready !== eld ||
            lcount !== ec || lerr !== ee) begin
            nbad++;
            $display("FAIL %s: got valid=%0b instr=%h loading=%0b ready=%0b count=%0d err=%0b; want valid=%0b instr=%h loading=%0b ready=%0b count=%0d err=%0b",
                     name, ivalid, instr, loading, lready, lcount, lerr,
                     ev, ei, eld, eld, ec, ee);
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        lv = 1'b1; lb = b;
        step();
        lv = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nbad = 0;
        idle_inputs();

        // --- reset, two-word load, fetch results and hold ---
        vq.push_back(mk(1,0,0,  0,0,8'h00,0, 0,DEF,0,0,0));
        vq.push_back(mk(0,0,0,  1,0,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,1,0,  0,1,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,1,1,  0,1,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h14,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h01,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,1,8'hFE,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,1,8'hFF,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,1,8'h02,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,1,8'h02,0, 0,DEF,1,2,0));
        vq.push_back(mk(0,0,0,  0,0,8'h00,1, 0,DEF,0,2,0));
        vq.push_back(mk(0,1,0,  0,0,8'h00,0, 1,28'h1140000,0,2,0));
        vq.push_back(mk(0,1,1,  0,0,8'h00,0, 1,28'h202FFFE,0,2,0));
        vq.push_back(mk(0,1,300,0,0,8'h00,0, 1,DEF,0,2,0));
        vq.push_back(mk(0,1,0,  0,0,8'h00,0, 1,28'h1140000,0,2,0));
        vq.push_back(mk(0,0,1,  0,0,8'h00,0, 0,28'h1140000,0,2,0));
        // --- fetch held high in LOAD; last byte together with done ---
        vq.push_back(mk(0,1,0,  1,0,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,1,0,  0,1,8'h11,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,1,0,  0,1,8'h22,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,1,0,  0,1,8'h33,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,1,0,  0,1,8'h44,1, 0,DEF,0,1,0));
        vq.push_back(mk(0,1,0,  0,0,8'h00,0, 1,28'h4332211,0,1,0));
        // --- partial word at done ---
        vq.push_back(mk(0,0,0,  1,0,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'hAA,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'hBB,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'hCC,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,0,8'h00,1, 0,DEF,0,0,1));
        vq.push_back(mk(0,1,0,  0,0,8'h00,0, 1,28'h4332211,0,0,1));
        // --- reset mid-load, then restart inside LOAD ---
        vq.push_back(mk(0,0,0,  1,0,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h01,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h02,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h03,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h04,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,1,8'h05,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,1,8'h06,0, 0,DEF,1,1,0));
        vq.push_back(mk(1,0,0,  0,0,8'h00,0, 0,DEF,0,0,0));
        vq.push_back(mk(0,1,0,  0,0,8'h00,0, 1,28'h4030201,0,0,0));
        vq.push_back(mk(0,1,1,  0,0,8'h00,0, 1,28'h202FFFE,0,0,0));
        vq.push_back(mk(0,0,0,  1,0,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h99,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  1,0,8'h00,1, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h00,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'hA0,0, 0,DEF,1,0,0));
        vq.push_back(mk(0,0,0,  0,1,8'h00,0, 0,DEF,1,1,0));
        vq.push_back(mk(0,0,0,  0,0,8'h00,1, 0,DEF,0,1,0));
        vq.push_back(mk(0,1,0,  0,0,8'h00,0, 1,28'h0A00000,0,1,0));
        vq.push_back(mk(0,1,1,  0,0,8'h00,0, 1,28'h202FFFE,0,1,0));

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; fe = vq[i].fe; addr = vq[i].addr;
            ls  = vq[i].ls;  lv = vq[i].lv; lb   = vq[i].lb; ld = vq[i].ld;
            step();
            check($sformatf("vec%0d", i), vq[i].ev, vq[i].ei, vq[i].eld, vq[i].ec, vq[i].ee);
        end
        idle_inputs();

        // --- overflow: DEPTH+1 words, word k = {00, k, 5A, k} ---
        ls = 1'b1;
        step();
        ls = 1'b0;
        check("ovf_start", 1'b0, DEF, 1'b1, '0, 1'b0);
        for (int k = 0; k <= DEPTH; k++) begin
            send_byte(8'(k));
            send_byte(8'h5A);
            send_byte(8'(k));
            send_byte(8'h00);
            check($sformatf("ovf_word%0d", k), 1'b0, DEF, 1'b1,
                  AW'((k + 1 > DEPTH) ? DEPTH : k + 1), (k == DEPTH));
        end
        ld = 1'b1;
        step();
        ld = 1'b0;
        check("ovf_done", 1'b0, DEF, 1'b0, AW'(DEPTH), 1'b1);

        fe = 1'b1; addr = 16'd0;
        step();
        check("ovf_mem0", 1'b1, 28'h0005A00, 1'b0, AW'(DEPTH), 1'b1);
        addr = 16'(DEPTH - 1);
        step();
        check("ovf_mem_last", 1'b1, 28'h0075A07, 1'b0, AW'(DEPTH), 1'b1);
        addr = 16'(DEPTH);
        step();
        check("ovf_unmapped", 1'b1, DEF, 1'b0, AW'(DEPTH), 1'b1);
        fe = 1'b0;
        step();
        check("ovf_idle", 1'b0, DEF, 1'b0, AW'(DEPTH), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
